// File: rtl/cbus_pkg.sv
// ---------------------------------------------------------------------------
// cbus_pkg
// Shared definitions for the CBUS responder endpoint.
//   - cbus_state_e  : handshake FSM state encoding
//   - CBUS_RD/WR    : encoding of the i_cbus_rw request bit
//   - ERR_CNT_W     : width of the optional out-of-range access counter
//   - err_cnt_off() : word offset of that counter inside a port block
// ---------------------------------------------------------------------------
package cbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_REL  = 2'd3
  } cbus_state_e;

  localparam logic CBUS_RD = 1'b1;
  localparam logic CBUS_WR = 1'b0;

  localparam int ERR_CNT_W = 16;
  localparam int DLY_W     = 4;

  // The error counter lives in the last word of the port block.
  function automatic int err_cnt_off(input int block_size);
    return block_size - 1;
  endfunction

endpackage

// File: rtl/cbus_slv_regs_if.sv
// ---------------------------------------------------------------------------
// cbus_slv_regs_if
// One per-port CBUS sub-bus. Signal prefixes are from the responder's view.
//   i_cbus_req   : request, held by the initiator until ack
//   i_cbus_rw    : 1 = read, 0 = write
//   i_cbus_addr  : word address (ADDR_W)
//   i_cbus_wdata : write data (DATA_W)
//   o_cbus_ack   : single-cycle completion pulse
//   o_cbus_rdata : read data, non-zero only during the ack cycle
// Modports: master (initiator side), slave (responder side).
// ---------------------------------------------------------------------------
interface cbus_slv_regs_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
);
  logic              i_cbus_req;
  logic              i_cbus_rw;
  logic [ADDR_W-1:0] i_cbus_addr;
  logic [DATA_W-1:0] i_cbus_wdata;
  logic              o_cbus_ack;
  logic [DATA_W-1:0] o_cbus_rdata;

  modport master (
    output i_cbus_req, i_cbus_rw, i_cbus_addr, i_cbus_wdata,
    input  o_cbus_ack, o_cbus_rdata
  );

  modport slave (
    input  i_cbus_req, i_cbus_rw, i_cbus_addr, i_cbus_wdata,
    output o_cbus_ack, o_cbus_rdata
  );
endinterface

// File: rtl/cbus_slv_fsm.sv
// ---------------------------------------------------------------------------
// cbus_slv_fsm
// Handshake FSM (IDLE -> WAIT -> ACK -> REL) with ACK_DLY wait states.
// Ports:
//   i_clk_sys, i_rst_sys_n : clock, asynchronous active-low reset
//   i_req                  : CBUS request
//   o_accept               : request is being accepted on this edge
//   o_ack_go               : FSM enters ACK on this edge
//   o_abort                : request dropped during WAIT, abandoned on this edge
//   o_ack                  : registered ack, high for exactly the ACK cycle
// ---------------------------------------------------------------------------
module cbus_slv_fsm
  import cbus_pkg::*;
#(
  parameter int ACK_DLY = 0
) (
  input  logic i_clk_sys,
  input  logic i_rst_sys_n,
  input  logic i_req,
  output logic o_accept,
  output logic o_ack_go,
  output logic o_abort,
  output logic o_ack
);

  localparam logic [DLY_W-1:0] DLY = DLY_W'(ACK_DLY);

  cbus_state_e      r_state;
  logic [DLY_W-1:0] r_cnt;
  logic             r_ack;

  logic w_accept;
  logic w_ack_go;
  logic w_abort;

  // Edge-qualifiers; the datapath in the top latches on these.
  always_comb begin
    w_accept = (r_state == ST_IDLE) && i_req;
    w_abort  = (r_state == ST_WAIT) && !i_req;
    w_ack_go = (w_accept && (DLY == '0)) ||
               ((r_state == ST_WAIT) && i_req && (r_cnt == DLY_W'(1)));
  end

  always_ff @(posedge i_clk_sys or negedge i_rst_sys_n) begin
    if (!i_rst_sys_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_ack <= w_ack_go;
      case (r_state)
        ST_IDLE: begin
          if (i_req) begin
            r_cnt   <= DLY;
            r_state <= (DLY == '0) ? ST_ACK : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!i_req) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else if (r_cnt == DLY_W'(1)) begin
            r_cnt   <= '0;
            r_state <= ST_ACK;
          end else begin
            r_cnt <= r_cnt - DLY_W'(1);
          end
        end
        ST_ACK: r_state <= ST_REL;
        // A request still held after ack must be released before re-serving.
        ST_REL: if (!i_req) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_accept = w_accept;
  assign o_ack_go = w_ack_go;
  assign o_abort  = w_abort;
  assign o_ack    = r_ack;

endmodule

// File: rtl/cbus_slv_regs.sv
// ---------------------------------------------------------------------------
// cbus_slv_regs
// CBUS responder endpoint exposing REG_NUM read/write control registers and
// STS_NUM read-only status registers, with ACK_DLY wait states.
// Optional feature macro: CBUS_SLV_ERR_CNT_EN -- 16-bit saturating counter of
// out-of-range accesses, readable at offset CFG_BLOCK_SIZE-1, cleared by any
// write to that offset.
// Ports:
//   i_clk_sys, i_rst_sys_n : clock, asynchronous active-low reset
//   cbus                   : CBUS sub-bus (slave modport)
//   o_reg_ctrl             : control registers, reg i at [i*DATA_W +: DATA_W]
//   o_reg_wr_stb           : one-cycle strobe when control reg i is written
//   i_reg_sts              : status values, status j at [j*DATA_W +: DATA_W]
//   o_sts_rd_stb           : one-cycle strobe when status j is read
// ---------------------------------------------------------------------------
module cbus_slv_regs
  import cbus_pkg::*;
#(
  parameter int ADDR_W         = 20,
  parameter int DATA_W         = 32,
  parameter int CFG_BLOCK_SIZE = 1024,
  parameter int REG_NUM        = 8,
  parameter int STS_NUM        = 4,
  parameter int ACK_DLY        = 0
) (
  input  logic                       i_clk_sys,
  input  logic                       i_rst_sys_n,
  cbus_slv_regs_if.slave             cbus,
  output logic [REG_NUM*DATA_W-1:0]  o_reg_ctrl,
  output logic [REG_NUM-1:0]         o_reg_wr_stb,
  input  logic [STS_NUM*DATA_W-1:0]  i_reg_sts,
  output logic [STS_NUM-1:0]         o_sts_rd_stb
);

  localparam int OFF_W = $clog2(CFG_BLOCK_SIZE);

  logic w_accept;
  logic w_ack_go;
  logic w_abort_unused;
  logic w_ack;

  cbus_slv_fsm #(.ACK_DLY(ACK_DLY)) u_fsm (
    .i_clk_sys   (i_clk_sys),
    .i_rst_sys_n (i_rst_sys_n),
    .i_req       (cbus.i_cbus_req),
    .o_accept    (w_accept),
    .o_ack_go    (w_ack_go),
    .o_abort     (w_abort_unused),
    .o_ack       (w_ack)
  );

  // Block-select bits are decoded upstream.
  logic w_unused_addr;
  assign w_unused_addr = ^cbus.i_cbus_addr[ADDR_W-1:OFF_W];

  logic              r_rw;
  logic [OFF_W-1:0]  r_off;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [REG_NUM-1:0] r_wr_stb;
  logic [STS_NUM-1:0] r_rd_stb;

  logic [DATA_W-1:0] w_ctrl [REG_NUM];

  // With ACK_DLY=0 the FSM enters ACK on the accept edge itself, so the
  // decode must see the live bus fields rather than the captured copies.
  logic             w_rw;
  logic [OFF_W-1:0] w_off;

  always_comb begin
    w_rw  = r_rw;
    w_off = r_off;
    if (w_accept) begin
      w_rw  = cbus.i_cbus_rw;
      w_off = cbus.i_cbus_addr[OFF_W-1:0];
    end
  end

`ifdef CBUS_SLV_ERR_CNT_EN
  localparam logic [OFF_W-1:0] ERR_OFF = OFF_W'(err_cnt_off(CFG_BLOCK_SIZE));
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic                 w_oor;
`endif

  logic [DATA_W-1:0]  w_rdata_next;
  logic [REG_NUM-1:0] w_wr_stb_next;
  logic [STS_NUM-1:0] w_rd_stb_next;

  always_comb begin
    w_rdata_next  = '0;
    w_wr_stb_next = '0;
    w_rd_stb_next = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      if (w_off == OFF_W'(i)) begin
        w_rdata_next     = w_ctrl[i];
        w_wr_stb_next[i] = (w_rw == CBUS_WR);
      end
    end
    for (int j = 0; j < STS_NUM; j++) begin
      if (w_off == OFF_W'(REG_NUM + j)) begin
        w_rdata_next     = i_reg_sts[j*DATA_W +: DATA_W];
        w_rd_stb_next[j] = (w_rw == CBUS_RD);
      end
    end
`ifdef CBUS_SLV_ERR_CNT_EN
    w_oor = (w_off >= OFF_W'(REG_NUM + STS_NUM));
    if (w_off == ERR_OFF) begin
      w_oor        = 1'b0;
      w_rdata_next = DATA_W'(r_err_cnt);
    end
`endif
    if (w_rw == CBUS_WR) w_rdata_next = '0;
  end

  // Read data and strobes are loaded on the edge entering ACK and cleared on
  // the next edge, so they are non-zero only while o_cbus_ack is high.
  always_ff @(posedge i_clk_sys or negedge i_rst_sys_n) begin
    if (!i_rst_sys_n) begin
      r_rw     <= CBUS_WR;
      r_off    <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_wr_stb <= '0;
      r_rd_stb <= '0;
    end else begin
      if (w_accept) begin
        r_rw    <= cbus.i_cbus_rw;
        r_off   <= cbus.i_cbus_addr[OFF_W-1:0];
        r_wdata <= cbus.i_cbus_wdata;
      end
      if (w_ack_go) begin
        r_rdata  <= w_rdata_next;
        r_wr_stb <= w_wr_stb_next;
        r_rd_stb <= w_rd_stb_next;
      end else begin
        r_rdata  <= '0;
        r_wr_stb <= '0;
        r_rd_stb <= '0;
      end
    end
  end

  // Control registers update at the end of the ACK cycle (strobe cycle).
  for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_ctrl
    logic [DATA_W-1:0] r_ctrl_word;
    always_ff @(posedge i_clk_sys or negedge i_rst_sys_n) begin
      if (!i_rst_sys_n) r_ctrl_word <= '0;
      else if (r_wr_stb[gi]) r_ctrl_word <= r_wdata;
    end
    assign w_ctrl[gi] = r_ctrl_word;
    assign o_reg_ctrl[gi*DATA_W +: DATA_W] = r_ctrl_word;
  end

`ifdef CBUS_SLV_ERR_CNT_EN
  // During ACK no accept is possible, so w_off/w_rw reflect the captured request.
  always_ff @(posedge i_clk_sys or negedge i_rst_sys_n) begin
    if (!i_rst_sys_n) begin
      r_err_cnt <= '0;
    end else if (w_ack) begin
      if ((w_rw == CBUS_WR) && (w_off == ERR_OFF)) r_err_cnt <= '0;
      else if (w_oor && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end
  end
`endif

  assign cbus.o_cbus_ack   = w_ack;
  assign cbus.o_cbus_rdata = r_rdata;
  assign o_reg_wr_stb      = r_wr_stb;
  assign o_sts_rd_stb      = r_rd_stb;

endmodule

// File: tb/tb_cbus_slv_regs.sv
// ---------------------------------------------------------------------------
// tb_cbus_slv_regs
// Three responders (ACK_DLY = 0, 3, 5) share one stimulated bus; each test
// observes one of them. Directed vectors with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_cbus_slv_regs;

  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         req   = 1'b0;
  logic         rw    = 1'b0;
  logic [19:0]  addr  = '0;
  logic [31:0]  wdata = '0;
  logic [127:0] sts   = '0;

  logic         ack_a   [3];
  logic [31:0]  rdata_a [3];
  logic [255:0] ctrl_a  [3];
  logic [7:0]   wstb_a  [3];
  logic [3:0]   sstb_a  [3];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int DLY = (gi == 0) ? 0 : ((gi == 1) ? 3 : 5);
    cbus_slv_regs_if #(.ADDR_W(20), .DATA_W(32)) bus ();
    logic [255:0] ctrl;
    logic [7:0]   wstb;
    logic [3:0]   sstb;
    assign bus.i_cbus_req   = req;
    assign bus.i_cbus_rw    = rw;
    assign bus.i_cbus_addr  = addr;
    assign bus.i_cbus_wdata = wdata;
    cbus_slv_regs #(
      .ADDR_W(20), .DATA_W(32), .CFG_BLOCK_SIZE(1024),
      .REG_NUM(8), .STS_NUM(4), .ACK_DLY(DLY)
    ) dut (
      .i_clk_sys    (clk),
      .i_rst_sys_n  (rst_n),
      .cbus         (bus),
      .o_reg_ctrl   (ctrl),
      .o_reg_wr_stb (wstb),
      .i_reg_sts    (sts),
      .o_sts_rd_stb (sstb)
    );
    assign ack_a[gi]   = bus.o_cbus_ack;
    assign rdata_a[gi] = bus.o_cbus_rdata;
    assign ctrl_a[gi]  = ctrl;
    assign wstb_a[gi]  = wstb;
    assign sstb_a[gi]  = sstb;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Results of the last access
  int           res_lat;
  int           res_nack;
  int           res_bad;
  logic [31:0]  res_rd;
  logic [7:0]   res_wstb;
  logic [3:0]   res_sstb;
  logic [255:0] res_ctrl_at;
  logic [255:0] res_ctrl_after;

  task automatic sample(input int sel, input int cyc);
    if (ack_a[sel]) begin
      res_nack++;
      if (res_lat < 0) res_lat = cyc;
      res_rd      = rdata_a[sel];
      res_wstb    = wstb_a[sel];
      res_sstb    = sstb_a[sel];
      res_ctrl_at = ctrl_a[sel];
    end else if (rdata_a[sel] != 0 || wstb_a[sel] != 0 || sstb_a[sel] != 0) begin
      res_bad++;
    end
  endtask

  // Raise req, hold it until 'hold' cycles after ack (or 'limit' cycles),
  // drop it, then watch 8 more cycles for stray acks/data/strobes.
  task automatic access(input int sel, input logic rw_i, input int off,
                        input logic [31:0] wd, input int hold, input int limit);
    res_lat = -1; res_nack = 0; res_bad = 0;
    res_rd = '0; res_wstb = '0; res_sstb = '0; res_ctrl_at = '0; res_ctrl_after = '0;
    @(negedge clk);
    rw    = rw_i;
    addr  = 20'hA5000 | 20'(off);
    wdata = wd;
    req   = 1'b1;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      @(negedge clk);
      sample(sel, cyc);
      if (res_lat >= 0 && cyc >= res_lat + hold) break;
    end
    req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) res_ctrl_after = ctrl_a[sel];
      sample(sel, -1);
    end
    $display("txn dut%0d %s off=%0d wdata=%h lat=%0d acks=%0d rdata=%h",
             sel, (rw_i == RD) ? "RD" : "WR", off, wd, res_lat, res_nack, res_rd);
  endtask

  logic [255:0] model0;
  int           stray;

  initial begin
    sts = {32'hA5A5_0003, 32'h0000_2222, 32'h1234_5678, 32'h0000_0F00};

    // Reset
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_ack%0d", d), 256'(ack_a[d]), 256'd0);
      check($sformatf("rst_rdata%0d", d), 256'(rdata_a[d]), 256'd0);
      check($sformatf("rst_ctrl%0d", d), ctrl_a[d], 256'd0);
      check($sformatf("rst_stb%0d", d), 256'({wstb_a[d], sstb_a[d]}), 256'd0);
    end
    rst_n = 1'b1;
    model0 = '0;

    // ACK_DLY=0 write 0xDEADBEEF to offset 2
    access(0, WR, 2, 32'hDEADBEEF, 0, 40);
    model0[2*32 +: 32] = 32'hDEADBEEF;
    check("w2_lat", res_lat, 1);
    check("w2_nack", res_nack, 1);
    check("w2_wstb", 256'(res_wstb), 256'h04);
    check("w2_rdata", 256'(res_rd), 256'd0);
    check("w2_bad", res_bad, 0);
    check("w2_ctrl_at_ack", res_ctrl_at, 256'd0);
    check("w2_ctrl_after", res_ctrl_after, model0);

    // Read back offset 2
    access(0, RD, 2, 32'h0, 0, 40);
    check("r2_lat", res_lat, 1);
    check("r2_rdata", 256'(res_rd), 256'hDEADBEEF);
    check("r2_stb", 256'({res_wstb, res_sstb}), 256'd0);

    // ACK_DLY=3 read status 1
    access(1, RD, 9, 32'h0, 0, 40);
    check("s1_lat", res_lat, 4);
    check("s1_nack", res_nack, 1);
    check("s1_rdata", 256'(res_rd), 256'h12345678);
    check("s1_sstb", 256'(res_sstb), 256'h2);
    check("s1_wstb", 256'(res_wstb), 256'd0);
    check("s1_bad", res_bad, 0);

    // ACK_DLY=5 abort: req dropped before the edge of cycle 3
    access(2, WR, 3, 32'h11111111, 0, 2);
    check("ab_nack", res_nack, 0);
    check("ab_bad", res_bad, 0);
    check("ab_ctrl", ctrl_a[2], 256'd0);
    // dut0 served that same request
    model0[3*32 +: 32] = 32'h11111111;
    check("ab_dut0_ctrl", ctrl_a[0], model0);

    // Next request on ACK_DLY=5 is served normally
    access(2, WR, 3, 32'h0BADF00D, 0, 40);
    model0[3*32 +: 32] = 32'h0BADF00D;
    check("w3_lat", res_lat, 6);
    check("w3_nack", res_nack, 1);
    check("w3_wstb", 256'(res_wstb), 256'h08);
    check("w3_ctrl_after", res_ctrl_after, 256'h0BADF00D << 96);

    // Req held 10 cycles after ack: exactly one ack, then a fresh access works
    access(0, RD, 3, 32'h0, 10, 40);
    check("hold_nack", res_nack, 1);
    check("hold_rdata", 256'(res_rd), 256'h0BADF00D);
    access(0, RD, 2, 32'h0, 0, 40);
    check("hold2_nack", res_nack, 1);
    check("hold2_rdata", 256'(res_rd), 256'hDEADBEEF);

    // Write to a status offset is dropped but acked
    access(0, WR, 8, 32'hCAFEF00D, 0, 40);
    check("ws_lat", res_lat, 1);
    check("ws_stb", 256'({res_wstb, res_sstb}), 256'd0);
    check("ws_ctrl", res_ctrl_after, model0);

    // Last status offset
    access(0, RD, 11, 32'h0, 0, 40);
    check("s3_rdata", 256'(res_rd), 256'hA5A50003);
    check("s3_sstb", 256'(res_sstb), 256'h8);

    // Out-of-range read/write
    access(0, RD, 500, 32'h0, 0, 40);
    check("oor_r_nack", res_nack, 1);
    check("oor_r_rdata", 256'(res_rd), 256'd0);
    check("oor_r_stb", 256'({res_wstb, res_sstb}), 256'd0);
    access(0, WR, 500, 32'hFFFFFFFF, 0, 40);
    check("oor_w_nack", res_nack, 1);
    check("oor_w_wstb", 256'(res_wstb), 256'd0);
    check("oor_w_ctrl", res_ctrl_after, model0);

`ifdef CBUS_SLV_ERR_CNT_EN
    access(0, RD, 1023, 32'h0, 0, 40);
    check("err_cnt2", 256'(res_rd), 256'd2);
    access(0, WR, 1023, 32'h5, 0, 40);
    check("err_clr_nack", res_nack, 1);
    access(0, RD, 1023, 32'h0, 0, 40);
    check("err_cnt0", 256'(res_rd), 256'd0);
`else
    access(0, RD, 1023, 32'h0, 0, 40);
    check("off1023_rdata", 256'(res_rd), 256'd0);
    check("off1023_nack", res_nack, 1);
`endif

    // First out-of-range offset
    access(0, RD, 12, 32'h0, 0, 40);
    check("oor12_rdata", 256'(res_rd), 256'd0);
    check("oor12_sstb", 256'(res_sstb), 256'd0);

    // Reset asserted during WAIT on ACK_DLY=5
    @(negedge clk);
    rw = WR; addr = 20'h00005; wdata = 32'h77777777; req = 1'b1;
    repeat (3) @(negedge clk);
    check("mrst_pre_ack", 256'(ack_a[2]), 256'd0);
    check("mrst_pre_ctrl", ctrl_a[2], 256'h0BADF00D << 96);
    rst_n = 1'b0;
    #1;
    check("mrst_ack", 256'(ack_a[2]), 256'd0);
    check("mrst_rdata", 256'(rdata_a[2]), 256'd0);
    check("mrst_ctrl2", ctrl_a[2], 256'd0);
    check("mrst_ctrl0", ctrl_a[0], 256'd0);
    check("mrst_stb", 256'({wstb_a[2], sstb_a[2]}), 256'd0);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) if (ack_a[d] || wstb_a[d] != 0) stray++;
    end
    $display("txn reset during WAIT, stray acks/strobes after release=%0d", stray);
    check("mrst_no_ack", stray, 0);
    check("mrst_ctrl_after", ctrl_a[2], 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
